// File: rtl/mc_ctrl_fsm_v2.sv
// mc_ctrl_fsm_v2 -- multicycle control unit for the 4-bit-opcode datapath.
//
// Sequences fetch / decode / execute and drives every datapath strobe. Memory
// accesses (fetch, load, store) wait on mem_ready with a bounded wait counter
// that traps on timeout. Undefined opcodes trap or retire as NOP. Two
// saturating counters report retired instructions and active cycles.
//
// Ports
//   clock          in   1      system clock, all state on rising edge
//   reset          in   1      synchronous active-low reset
//   instr          in   4      opcode field of IR
//   N, Z           in   1      ALU flags used by branches
//   mem_ready      in   1      memory completes the current access this cycle
//   stall          in   1      hold before fetch (looked at in C1 only)
//   PCwrite .. FlagWrite  out 1 each  datapath strobes
//   R1Sel          out  2      register-file port-1 select
//   ALU2, ALUop    out  3 each ALU operand-2 select / operation
//   trap           out  1      high while in TRAP
//   instr_count    out  CNT_W  retired instructions, saturating
//   cycle_count    out  CNT_W  active cycles (not RST/TRAP), saturating
//
// state | meaning
// RST   | reset, all outputs low
// C1    | fetch (or stalled before fetch)
// C2    | decode, load R1/R2
// ASN3  | add/sub/nand ALU op
// SH3   | shift ALU op
// EX4   | write ALU result back
// ORI3  | reselect R1 for ori
// ORI4  | ori ALU op
// ORI5  | ori write-back
// LD3   | memory read into MDR
// LD4   | load write-back
// ST3   | memory write
// BPZ   | branch if N==0
// BZ    | branch if Z==1
// BNZ   | branch if Z==0
// JAL3  | compute link value
// JAL4  | write link register
// JAL5  | jump
// JMP3  | jump
// TRAP  | fatal halt, exits only via reset

module mc_ctrl_fsm_v2 #(
    parameter int WAIT_W       = 4,
    parameter int WAIT_MAX     = 15,
    parameter int CNT_W        = 16,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       instr,
    input  logic             N,
    input  logic             Z,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             PCwrite,
    output logic             AddrSel,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRload,
    output logic             MDRload,
    output logic             R1R2Load,
    output logic             ALU1,
    output logic             ALUOutWrite,
    output logic             RFWrite,
    output logic             RegIn,
    output logic             FlagWrite,
    output logic [1:0]       R1Sel,
    output logic [2:0]       ALU2,
    output logic [2:0]       ALUop,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [4:0] {
        S_RST, S_C1, S_C2, S_ASN3, S_SH3, S_EX4, S_ORI3, S_ORI4, S_ORI5,
        S_LD3, S_LD4, S_ST3, S_BPZ, S_BZ, S_BNZ, S_JAL3, S_JAL4, S_JAL5,
        S_JMP3, S_TRAP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              wait_to;
    logic              retire;

    assign wait_to = (wait_cnt == WAIT_W'(WAIT_MAX));
    // Any entry into C1 from an execute state (or the NOP path out of C2)
    // retires one instruction; C1->C1 (stall/wait) and RST->C1 do not.
    assign retire  = (state_nxt == S_C1) && (state != S_C1) && (state != S_RST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_RST;
            wait_cnt    <= '0;
            instr_count <= '0;
            cycle_count <= '0;
        end else begin
            state <= state_nxt;
            // Leaving a state always clears the wait count, so every memory
            // state starts its access with a fresh budget.
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (mem_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (retire && (instr_count != CNT_MAX)) begin
                instr_count <= instr_count + 1'b1;
            end
            if ((state != S_RST) && (state != S_TRAP) && (cycle_count != CNT_MAX)) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_wait    = 1'b0;
        PCwrite     = 1'b0;
        AddrSel     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRload      = 1'b0;
        MDRload     = 1'b0;
        R1R2Load    = 1'b0;
        ALU1        = 1'b0;
        ALUOutWrite = 1'b0;
        RFWrite     = 1'b0;
        RegIn       = 1'b0;
        FlagWrite   = 1'b0;
        R1Sel       = 2'b00;
        ALU2        = 3'b000;
        ALUop       = 3'b000;
        trap        = 1'b0;

        case (state)
            S_RST: state_nxt = S_C1;

            S_C1: begin
                if (!stall) begin
                    AddrSel = 1'b1;
                    MemRead = 1'b1;
                    ALU2    = 3'b001;
                    PCwrite = mem_ready;
                    IRload  = mem_ready;
                    if (mem_ready) begin
                        state_nxt = S_C2;
                    end else begin
                        mem_wait = 1'b1;
                        if (wait_to) state_nxt = S_TRAP;
                    end
                end
            end

            S_C2: begin
                R1R2Load = 1'b1;
                casez (instr)
                    4'b0100, 4'b0110, 4'b1000: state_nxt = S_ASN3;
                    4'b?011: state_nxt = S_SH3;
                    4'b?111: state_nxt = S_ORI3;
                    4'b0000: state_nxt = S_LD3;
                    4'b0010: state_nxt = S_ST3;
                    4'b1101: state_nxt = S_BPZ;
                    4'b0101: state_nxt = S_BZ;
                    4'b1001: state_nxt = S_BNZ;
                    4'b1100: state_nxt = S_JAL3;
                    4'b1110: state_nxt = S_JMP3;
                    default: state_nxt = TRAP_ILLEGAL ? S_TRAP : S_C1;
                endcase
            end

            S_ASN3: begin
                ALU1        = 1'b1;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                case (instr)
                    4'b0110: ALUop = 3'b001;
                    4'b1000: ALUop = 3'b011;
                    default: ALUop = 3'b000;
                endcase
                state_nxt = S_EX4;
            end

            S_SH3: begin
                ALU1        = 1'b1;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                ALU2        = 3'b100;
                ALUop       = 3'b100;
                state_nxt   = S_EX4;
            end

            S_EX4: begin
                RFWrite   = 1'b1;
                state_nxt = S_C1;
            end

            S_ORI3: begin
                R1Sel     = 2'b10;
                R1R2Load  = 1'b1;
                state_nxt = S_ORI4;
            end

            S_ORI4: begin
                ALU1        = 1'b1;
                ALU2        = 3'b011;
                ALUop       = 3'b010;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                state_nxt   = S_ORI5;
            end

            S_ORI5: begin
                R1Sel     = 2'b10;
                RFWrite   = 1'b1;
                state_nxt = S_C1;
            end

            S_LD3: begin
                MemRead = 1'b1;
                MDRload = mem_ready;
                if (mem_ready) begin
                    state_nxt = S_LD4;
                end else begin
                    mem_wait = 1'b1;
                    if (wait_to) state_nxt = S_TRAP;
                end
            end

            S_LD4: begin
                ALUOutWrite = 1'b1;
                RFWrite     = 1'b1;
                RegIn       = 1'b1;
                state_nxt   = S_C1;
            end

            S_ST3: begin
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_C1;
                end else begin
                    mem_wait = 1'b1;
                    if (wait_to) state_nxt = S_TRAP;
                end
            end

            S_BPZ: begin
                ALU2      = 3'b010;
                PCwrite   = ~N;
                state_nxt = S_C1;
            end

            S_BZ: begin
                ALU2      = 3'b010;
                PCwrite   = Z;
                state_nxt = S_C1;
            end

            S_BNZ: begin
                ALU2      = 3'b010;
                PCwrite   = ~Z;
                state_nxt = S_C1;
            end

            S_JAL3: begin
                ALU2        = 3'b101;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                state_nxt   = S_JAL4;
            end

            S_JAL4: begin
                R1Sel     = 2'b10;
                RFWrite   = 1'b1;
                state_nxt = S_JAL5;
            end

            S_JAL5: begin
                PCwrite   = 1'b1;
                ALU2      = 3'b010;
                state_nxt = S_C1;
            end

            S_JMP3: begin
                PCwrite   = 1'b1;
                ALU1      = 1'b1;
                ALU2      = 3'b101;
                ALUop     = 3'b000;
                state_nxt = S_C1;
            end

            S_TRAP: trap = 1'b1;

            default: state_nxt = S_RST;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm_v2.sv
module tb_mc_ctrl_fsm_v2;

    localparam int WAIT_W   = 4;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 6;
    localparam int CMAX     = (1 << CNT_W) - 1;

    // observed control word: {trap, PCwrite, AddrSel, MemRead, MemWrite, IRload,
    // MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite,
    // R1Sel[1:0], ALU2[2:0], ALUop[2:0]}
    localparam logic [20:0] B_TRAP = 21'd1 << 20;
    localparam logic [20:0] B_PCW  = 21'd1 << 19;
    localparam logic [20:0] B_ADDR = 21'd1 << 18;
    localparam logic [20:0] B_MRD  = 21'd1 << 17;
    localparam logic [20:0] B_MWR  = 21'd1 << 16;
    localparam logic [20:0] B_IRL  = 21'd1 << 15;
    localparam logic [20:0] B_MDR  = 21'd1 << 14;
    localparam logic [20:0] B_R12  = 21'd1 << 13;
    localparam logic [20:0] B_ALU1 = 21'd1 << 12;
    localparam logic [20:0] B_AOW  = 21'd1 << 11;
    localparam logic [20:0] B_RFW  = 21'd1 << 10;
    localparam logic [20:0] B_RGI  = 21'd1 << 9;
    localparam logic [20:0] B_FW   = 21'd1 << 8;

    localparam int MD_RST   = 0;
    localparam int MD_FETCH = 1;
    localparam int MD_DEC   = 2;
    localparam int MD_EXEC  = 3;
    localparam int MD_TRAP  = 4;

    logic clock = 1'b0;
    logic reset, N, Z, mem_ready, stall;
    logic [3:0] instr;
    logic PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, R1R2Load, ALU1;
    logic ALUOutWrite, RFWrite, RegIn, FlagWrite, trap;
    logic [1:0] R1Sel;
    logic [2:0] ALU2, ALUop;
    logic [CNT_W-1:0] instr_count, cycle_count;

    logic d0_PCwrite, d0_AddrSel, d0_MemRead, d0_MemWrite, d0_IRload, d0_MDRload;
    logic d0_R1R2Load, d0_ALU1, d0_ALUOutWrite, d0_RFWrite, d0_RegIn, d0_FlagWrite, d0_trap;
    logic [1:0] d0_R1Sel;
    logic [2:0] d0_ALU2, d0_ALUop;
    logic [CNT_W-1:0] d0_instr_count, d0_cycle_count;

    logic [20:0] obs;
    assign obs = {trap, PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, R1R2Load,
                  ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, R1Sel, ALU2, ALUop};

    always #5 clock = ~clock;

    mc_ctrl_fsm_v2 #(.WAIT_W(WAIT_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W), .TRAP_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready),
        .stall(stall), .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRload(IRload), .MDRload(MDRload), .R1R2Load(R1R2Load),
        .ALU1(ALU1), .ALUOutWrite(ALUOutWrite), .RFWrite(RFWrite), .RegIn(RegIn),
        .FlagWrite(FlagWrite), .R1Sel(R1Sel), .ALU2(ALU2), .ALUop(ALUop), .trap(trap),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    mc_ctrl_fsm_v2 #(.WAIT_W(WAIT_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W), .TRAP_ILLEGAL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready),
        .stall(stall), .PCwrite(d0_PCwrite), .AddrSel(d0_AddrSel), .MemRead(d0_MemRead),
        .MemWrite(d0_MemWrite), .IRload(d0_IRload), .MDRload(d0_MDRload), .R1R2Load(d0_R1R2Load),
        .ALU1(d0_ALU1), .ALUOutWrite(d0_ALUOutWrite), .RFWrite(d0_RFWrite), .RegIn(d0_RegIn),
        .FlagWrite(d0_FlagWrite), .R1Sel(d0_R1Sel), .ALU2(d0_ALU2), .ALUop(d0_ALUop), .trap(d0_trap),
        .instr_count(d0_instr_count), .cycle_count(d0_cycle_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // An instruction is a list of micro-steps after decode; memory steps hold
    // until mem_ready, branch steps gate PCwrite on a flag condition.
    typedef struct {
        logic [20:0] ctl;
        bit          mem;
        logic [20:0] rdy;
        int          br;
    } step_t;

    step_t q[$];
    int md, wcnt, icnt, ccnt;

    function automatic logic [20:0] r1s(input int v); return 21'(v) << 6; endfunction
    function automatic logic [20:0] a2(input int v);  return 21'(v) << 3; endfunction
    function automatic logic [20:0] aop(input int v); return 21'(v);      endfunction

    function automatic step_t mk(input logic [20:0] c, input bit m, input logic [20:0] r, input int b);
        step_t s;
        s.ctl = c; s.mem = m; s.rdy = r; s.br = b;
        return s;
    endfunction

    task automatic expand(input logic [3:0] op);
        q.delete();
        if (op == 4'b0100 || op == 4'b0110 || op == 4'b1000) begin
            q.push_back(mk(B_ALU1 | B_AOW | B_FW | aop(op == 4'b0100 ? 0 : (op == 4'b0110 ? 1 : 3)), 0, '0, 0));
            q.push_back(mk(B_RFW, 0, '0, 0));
        end else if (op[2:0] == 3'b011) begin
            q.push_back(mk(B_ALU1 | B_AOW | B_FW | a2(4) | aop(4), 0, '0, 0));
            q.push_back(mk(B_RFW, 0, '0, 0));
        end else if (op[2:0] == 3'b111) begin
            q.push_back(mk(r1s(2) | B_R12, 0, '0, 0));
            q.push_back(mk(B_ALU1 | a2(3) | aop(2) | B_AOW | B_FW, 0, '0, 0));
            q.push_back(mk(r1s(2) | B_RFW, 0, '0, 0));
        end else if (op == 4'b0000) begin
            q.push_back(mk(B_MRD, 1, B_MDR, 0));
            q.push_back(mk(B_AOW | B_RFW | B_RGI, 0, '0, 0));
        end else if (op == 4'b0010) begin
            q.push_back(mk(B_MWR, 1, '0, 0));
        end else if (op == 4'b1101) begin
            q.push_back(mk(a2(2), 0, '0, 1));
        end else if (op == 4'b0101) begin
            q.push_back(mk(a2(2), 0, '0, 2));
        end else if (op == 4'b1001) begin
            q.push_back(mk(a2(2), 0, '0, 3));
        end else if (op == 4'b1100) begin
            q.push_back(mk(a2(5) | B_AOW | B_FW, 0, '0, 0));
            q.push_back(mk(r1s(2) | B_RFW, 0, '0, 0));
            q.push_back(mk(B_PCW | a2(2), 0, '0, 0));
        end else if (op == 4'b1110) begin
            q.push_back(mk(B_PCW | B_ALU1 | a2(5), 0, '0, 0));
        end
    endtask

    function automatic logic [20:0] exp_ctl(input logic st, input logic mr, input logic n, input logic z);
        logic [20:0] e;
        e = '0;
        if (md == MD_TRAP) begin
            e = B_TRAP;
        end else if (md == MD_FETCH) begin
            if (!st) e = B_ADDR | B_MRD | a2(1) | (mr ? (B_PCW | B_IRL) : 21'd0);
        end else if (md == MD_DEC) begin
            e = B_R12;
        end else if (md == MD_EXEC) begin
            e = q[0].ctl;
            if (q[0].mem && mr) e = e | q[0].rdy;
            if ((q[0].br == 1 && !n) || (q[0].br == 2 && z) || (q[0].br == 3 && !z)) e = e | B_PCW;
        end
        return e;
    endfunction

    task automatic mem_timeout_or_wait();
        if (wcnt == WAIT_MAX) begin
            md = MD_TRAP; wcnt = 0; q.delete();
        end else begin
            wcnt++;
        end
    endtask

    task automatic advance(input logic rs, input logic st, input logic mr, input logic [3:0] op);
        if (!rs) begin
            md = MD_RST; wcnt = 0; icnt = 0; ccnt = 0; q.delete();
            return;
        end
        if (md != MD_RST && md != MD_TRAP && ccnt < CMAX) ccnt++;
        case (md)
            MD_RST: begin md = MD_FETCH; wcnt = 0; end
            MD_FETCH: if (!st) begin
                if (mr) begin md = MD_DEC; wcnt = 0; end
                else mem_timeout_or_wait();
            end
            MD_DEC: begin
                expand(op);
                md = (q.size() == 0) ? MD_TRAP : MD_EXEC;
            end
            MD_EXEC: begin
                if (q[0].mem && !mr) begin
                    mem_timeout_or_wait();
                end else begin
                    void'(q.pop_front());
                    wcnt = 0;
                    if (q.size() == 0) begin
                        md = MD_FETCH;
                        if (icnt < CMAX) icnt++;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // one clock cycle: drive, compare against the model, step the model
    task automatic cyc(input logic rs, input logic st, input logic mr, input logic [3:0] op,
                       input logic n, input logic z);
        logic [20:0] e;
        @(negedge clock);
        reset = rs; stall = st; mem_ready = mr; instr = op; N = n; Z = z;
        #1;
        e = exp_ctl(st, mr, n, z);
        check("ctl", 32'(obs), 32'(e));
        check("instr_count", 32'(instr_count), 32'(icnt));
        check("cycle_count", 32'(cycle_count), 32'(ccnt));
        advance(rs, st, mr, op);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    logic [3:0] cur_op;
    logic r_rs, r_st, r_mr;

    initial begin
        reset = 1'b0; stall = 1'b0; mem_ready = 1'b0; instr = 4'b0; N = 1'b0; Z = 1'b0;
        md = MD_RST; wcnt = 0; icnt = 0; ccnt = 0;
        repeat (2) @(posedge clock);

        // ADD with memory always ready
        cyc(0, 0, 1, 4'b0100, 0, 0);
        repeat (5) cyc(1, 0, 1, 4'b0100, 0, 0);
        after_edge();
        check("add_icnt", 32'(instr_count), 32'd1);

        // LD with three wait cycles in the data access
        cyc(0, 0, 1, 4'b0000, 0, 0);
        repeat (3) cyc(1, 0, 1, 4'b0000, 0, 0);
        repeat (3) cyc(1, 0, 0, 4'b0000, 0, 0);
        cyc(1, 0, 1, 4'b0000, 0, 0);
        cyc(1, 0, 1, 4'b0000, 0, 0);
        after_edge();
        check("ld_icnt", 32'(instr_count), 32'd1);

        // fetch completing on the last allowed wait cycle
        cyc(0, 0, 1, 4'b0100, 0, 0);
        cyc(1, 0, 1, 4'b0100, 0, 0);
        repeat (WAIT_MAX) cyc(1, 0, 0, 4'b0100, 0, 0);
        cyc(1, 0, 1, 4'b0100, 0, 0);
        after_edge();
        check("edge_no_trap", 32'(trap), 32'd0);
        check("edge_decode", 32'(R1R2Load), 32'd1);

        // fetch timeout: 16 cycles without mem_ready
        cyc(0, 0, 1, 4'b0100, 0, 0);
        cyc(1, 0, 1, 4'b0100, 0, 0);
        repeat (WAIT_MAX + 1) cyc(1, 0, 0, 4'b0100, 0, 0);
        repeat (3) cyc(1, 0, 1, 4'b0100, 0, 0);
        after_edge();
        check("timeout_trap", 32'(trap), 32'd1);

        // BZ not taken, BZ taken, BPZ with N=1
        cyc(0, 0, 1, 4'b0101, 0, 0);
        repeat (3) cyc(1, 0, 1, 4'b0101, 0, 0);
        cyc(1, 0, 1, 4'b0101, 0, 0);
        repeat (2) cyc(1, 0, 1, 4'b0101, 0, 1);
        cyc(1, 0, 1, 4'b0101, 0, 1);
        repeat (2) cyc(1, 0, 1, 4'b1101, 1, 0);
        cyc(1, 0, 1, 4'b1101, 1, 0);
        after_edge();
        check("br_icnt", 32'(instr_count), 32'd3);

        // undefined opcode on both variants
        cyc(0, 0, 1, 4'b1010, 0, 0);
        repeat (3) cyc(1, 0, 1, 4'b1010, 0, 0);
        after_edge();
        check("ill_trap1", 32'(trap), 32'd1);
        check("ill_trap0", 32'(d0_trap), 32'd0);
        check("ill_icnt0", 32'(d0_instr_count), 32'd1);

        // five stall cycles, then reset in the middle of JAL
        cyc(0, 0, 1, 4'b1100, 0, 0);
        cyc(1, 0, 1, 4'b1100, 0, 0);
        repeat (5) cyc(1, 1, 0, 4'b1100, 0, 0);
        after_edge();
        check("stall_ccnt", 32'(cycle_count), 32'd5);
        repeat (3) cyc(1, 0, 1, 4'b1100, 0, 0);
        cyc(0, 0, 1, 4'b1100, 0, 0);
        after_edge();
        check("rst_icnt", 32'(instr_count), 32'd0);
        check("rst_ccnt", 32'(cycle_count), 32'd0);
        check("rst_ctl", 32'(obs), 32'd0);

        // long ADD run: both counters saturate
        cyc(0, 0, 1, 4'b0100, 0, 0);
        repeat (400) cyc(1, 0, 1, 4'b0100, 0, 0);
        after_edge();
        check("sat_icnt", 32'(instr_count), 32'(CMAX));
        check("sat_ccnt", 32'(cycle_count), 32'(CMAX));

        // randomized traffic
        cyc(0, 0, 1, 4'b0100, 0, 0);
        cur_op = 4'b0100;
        for (int i = 0; i < 4000; i++) begin
            if (md == MD_TRAP) r_rs = ($urandom_range(0, 3) != 0);
            else               r_rs = ($urandom_range(0, 399) != 0);
            if (md == MD_FETCH || md == MD_RST || md == MD_TRAP) begin
                cur_op = 4'($urandom_range(0, 15));
                if ((cur_op == 4'b0001 || cur_op == 4'b1010) && $urandom_range(0, 3) != 0)
                    cur_op = 4'b0110;
            end
            r_st = ($urandom_range(0, 5) == 0);
            r_mr = ($urandom_range(0, 3) != 0);
            cyc(r_rs, r_st, r_mr, cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
